// File: rtl/ram_dp_clr.sv
// Dual-port buffer RAM: port A read/write, port B read-only, with a hardware
// clear sequencer that fills every word with CLR_VAL after reset or on request.
module ram_dp_clr #(
  parameter int                DATA_W  = 12,
  parameter int                ADDR_W  = 8,
  parameter int                RD_REG  = 0,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  input  logic              a_ce,
  input  logic              a_we,
  output logic [DATA_W-1:0] a_dout,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_ce,
  output logic [DATA_W-1:0] b_dout,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_we;
  logic              a_wr;

  // The array is never touched while reset is held; the sweep owns it while busy.
  assign clr_we = ~reset & (state == CLEAR);
  assign a_wr   = ~reset & a_ce & a_we & ~busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          // Explicit last-address compare ends the sweep before the counter wraps.
          if (clr_addr == LAST) begin
            state    <= IDLE;
            busy     <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we)
      mem[clr_addr] <= CLR_VAL;
    else if (a_wr)
      mem[a_addr] <= a_din;
  end

  generate
    if (RD_REG != 0) begin : g_rd_reg
      // Registered reads sample the array before this edge's write lands.
      always_ff @(posedge clk) begin
        if (reset) begin
          a_dout <= '0;
          b_dout <= '0;
        end else begin
          if (a_ce) a_dout <= mem[a_addr];
          if (b_ce) b_dout <= mem[b_addr];
        end
      end
    end else begin : g_rd_comb
      assign a_dout = mem[a_addr];
      assign b_dout = mem[b_addr];
    end
  endgenerate
endmodule

// File: tb/tb_ram_dp_clr.sv
// Scoreboard bench: u0 is combinational-read with CLR_VAL=0, u1 is
// registered-read with CLR_VAL=0077; both share every input.
module tb_ram_dp_clr;
  logic        clk = 1'b0;
  logic        reset, a_ce, a_we, b_ce, clr_req;
  logic [7:0]  a_addr, b_addr;
  logic [11:0] a_din;
  logic [11:0] a_dout0, b_dout0, a_dout1, b_dout1;
  logic        busy0, busy1, done0, done1;

  localparam logic [11:0] CV1 = 12'o0077;

  always #5 clk = ~clk;

  ram_dp_clr #(.DATA_W(12), .ADDR_W(8), .RD_REG(0), .CLR_VAL(12'o0000)) u0 (
    .clk(clk), .reset(reset), .a_addr(a_addr), .a_din(a_din), .a_ce(a_ce),
    .a_we(a_we), .a_dout(a_dout0), .b_addr(b_addr), .b_ce(b_ce),
    .b_dout(b_dout0), .clr_req(clr_req), .busy(busy0), .clr_done(done0));

  ram_dp_clr #(.DATA_W(12), .ADDR_W(8), .RD_REG(1), .CLR_VAL(CV1)) u1 (
    .clk(clk), .reset(reset), .a_addr(a_addr), .a_din(a_din), .a_ce(a_ce),
    .a_we(a_we), .a_dout(a_dout1), .b_addr(b_addr), .b_ce(b_ce),
    .b_dout(b_dout1), .clr_req(clr_req), .busy(busy1), .clr_done(done1));

  // sig: 0 a_dout, 1 b_dout, 2 busy, 3 clr_done, 4 bench-side value in act
  typedef struct {
    string       name;
    int          dut;
    int          sig;
    logic [11:0] exp;
    logic [11:0] act;
  } chk_t;

  chk_t q[$];
  int   tests = 0;
  int   fails = 0;

  always @(negedge clk) begin
    chk_t        c;
    logic [11:0] v;
    while (q.size() > 0) begin
      c = q.pop_front();
      case (c.sig)
        0:       v = (c.dut == 0) ? a_dout0 : a_dout1;
        1:       v = (c.dut == 0) ? b_dout0 : b_dout1;
        2:       v = {11'd0, (c.dut == 0) ? busy0 : busy1};
        3:       v = {11'd0, (c.dut == 0) ? done0 : done1};
        default: v = c.act;
      endcase
      tests++;
      if (v !== c.exp) begin
        fails++;
        $display("FAIL %s (u%0d): got %o, expected %o", c.name, c.dut, v, c.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int dut, input int sig,
                     input logic [11:0] e, input logic [11:0] act = '0);
    chk_t c;
    c.name = name; c.dut = dut; c.sig = sig; c.exp = e; c.act = act;
    q.push_back(c);
  endtask

  task automatic wait_ok(input string name, input int n);
    tests++;
    if (n >= 400) begin
      fails++;
      $display("FAIL %s: busy never dropped within %0d edges", name, n);
    end
  endtask

  // u0 checked in the current cycle, u1 after its register loads.
  task automatic rd(input string name, input logic [7:0] addr,
                    input logic [11:0] e0, input logic [11:0] e1);
    a_addr = addr; b_addr = addr; a_ce = 1'b1; b_ce = 1'b1; a_we = 1'b0;
    chk({name, "_a"}, 0, 0, e0);
    chk({name, "_b"}, 0, 1, e0);
    tick();
    chk({name, "_a"}, 1, 0, e1);
    chk({name, "_b"}, 1, 1, e1);
  endtask

  task automatic count_sweep(input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (busy0 && n < 400);
    wait_ok({name, "_timeout"}, n);
    chk(name, 0, 4, 12'd256, 12'(n));
  endtask

  initial begin
    int n;
    reset = 1'b1; a_ce = 1'b0; a_we = 1'b0; b_ce = 1'b0; clr_req = 1'b0;
    a_addr = '0; b_addr = '0; a_din = '0;

    // reset and first sweep
    repeat (3) tick();
    tests++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1 || done0 !== 1'b0 || done1 !== 1'b0) begin
      fails++;
      $display("FAIL rst_state: busy %b/%b done %b/%b", busy0, busy1, done0, done1);
    end
    chk("rst_busy", 0, 2, 12'd1); chk("rst_busy", 1, 2, 12'd1);
    chk("rst_done", 0, 3, 12'd0);
    chk("rst_adout", 1, 0, 12'd0); chk("rst_bdout", 1, 1, 12'd0);
    reset = 1'b0;
    count_sweep("rst_sweep_len");
    chk("rst_done_pulse", 0, 3, 12'd1); chk("rst_done_pulse", 1, 3, 12'd1);
    chk("rst_busy_low", 1, 2, 12'd0);
    tick();
    chk("rst_done_end", 0, 3, 12'd0); chk("rst_done_end", 1, 3, 12'd0);
    rd("rst_m0", 8'd0, 12'o0, CV1);
    rd("rst_m128", 8'd128, 12'o0, CV1);
    rd("rst_m255", 8'd255, 12'o0, CV1);

    // combinational write-through on both ports
    a_addr = 8'o17; b_addr = 8'o17; a_din = 12'o7777; a_ce = 1'b1; a_we = 1'b1;
    tick();
    a_we = 1'b0;
    chk("wr17_b", 0, 1, 12'o7777); chk("wr17_a", 0, 0, 12'o7777);
    chk("wr17_rbw", 1, 0, CV1);
    tick();
    chk("wr17_next", 1, 0, 12'o7777);

    // registered read-before-write and b_ce hold
    a_addr = 8'd5; b_addr = 8'd5; b_ce = 1'b1;
    tick();
    chk("pre5_a", 1, 0, CV1); chk("pre5_b", 1, 1, CV1);
    a_din = 12'o1234; a_we = 1'b1; b_ce = 1'b0;
    tick();
    a_we = 1'b0; b_addr = 8'o17;
    chk("wr5_old", 1, 0, CV1); chk("wr5_comb", 0, 0, 12'o1234);
    tick();
    chk("wr5_new", 1, 0, 12'o1234); chk("bce_hold", 1, 1, CV1);

    // fill, clear request, dropped write and ignored second request
    a_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_addr = 8'(i); a_din = 12'(i + 1);
      tick();
    end
    for (int i = 0; i < 4; i++) rd("fill", 8'(i), 12'(i + 1), 12'(i + 1));
    a_addr = 8'd7; a_din = 12'o4321; a_we = 1'b1; clr_req = 1'b1;
    tick();
    clr_req = 1'b0; a_we = 1'b0;
    chk("req_busy", 0, 2, 12'd1); chk("req_busy", 1, 2, 12'd1);
    chk("req_wr_done", 0, 0, 12'o4321);
    n = 0;
    do begin
      a_we = (n == 10); a_addr = (n == 10) ? 8'd200 : 8'd7;
      a_din = 12'o5555; clr_req = (n == 50);
      tick();
      n++;
    end while (busy0 && n < 400);
    a_we = 1'b0; clr_req = 1'b0;
    wait_ok("req_sweep_timeout", n);
    chk("req_sweep_len", 0, 4, 12'd256, 12'(n));
    for (int i = 0; i < 4; i++) rd("req_clr", 8'(i), 12'o0, CV1);
    rd("req_clr7", 8'd7, 12'o0, CV1);
    rd("busy_wr200", 8'd200, 12'o0, CV1);

    // reset in the middle of a sweep
    a_we = 1'b1;
    a_addr = 8'd250; a_din = 12'o1111; tick();
    a_addr = 8'd2;   a_din = 12'o2222; tick();
    a_we = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 99; i++) begin
      if (i == 20) begin
        a_addr = 8'd250; b_addr = 8'd2;
        chk("part_uncleared", 0, 0, 12'o1111);
        chk("part_cleared", 0, 1, 12'o0);
      end
      tick();
    end
    reset = 1'b1;
    tick();
    chk("mid_rst_busy", 0, 2, 12'd1);
    repeat (2) tick();
    reset = 1'b0;
    count_sweep("mid_rst_sweep_len");
    for (int i = 0; i < 256; i++) rd("all_clr", 8'(i), 12'o0, CV1);

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
